// File: rtl/id_stage.sv
// id_stage: decode stage of the single-cycle R-type RISC-V core.
// Holds the 32 x XLEN register file (combinational reads, x0 hardwired to 0),
// decodes R-type opcode/funct3/funct7 into a 4-bit ALU select plus write
// enable, and keeps a sticky illegal-instruction flag and a retired counter.
//
// Optional feature (macro WB_BYPASS_EN):
//   defined   - a read of the register being written this cycle returns
//               wb_data_i (write-through)
//   undefined - reads return the stored value; a new value appears the
//               cycle after its writeback
module id_stage #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_data_i,
  input  logic             wb_en_i,
  input  logic [4:0]       wb_addr_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [4:0]       rd_addr_o,
  output logic [3:0]       alu_ctrl_o,
  output logic             reg_write_o,
  output logic             illegal_o,
  output logic             illegal_sticky_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic [4:0] rd_addr;

  assign opcode   = instr_data_i[6:0];
  assign rd_addr  = instr_data_i[11:7];
  assign funct3   = instr_data_i[14:12];
  assign rs1_addr = instr_data_i[19:15];
  assign rs2_addr = instr_data_i[24:20];
  assign funct7   = instr_data_i[31:25];

  // Architectural state
  logic [XLEN-1:0] regs [NREG];
  logic            wb_fire;
  logic            legal;
  logic [3:0]      alu_sel;

  // A write to x0 never fires, so x0 stays at its reset value of zero.
  assign wb_fire = wb_en_i && (wb_addr_i != 5'd0);

  // Register file write; reset clears every entry and drops a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_fire) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

  // Read port 1: stored value, optional write-through, x0 forced to zero
  always_comb begin
    rs1_data_o = regs[rs1_addr];
`ifdef WB_BYPASS_EN
    if (wb_fire && (wb_addr_i == rs1_addr)) begin
      rs1_data_o = wb_data_i;
    end
`endif
    if (rs1_addr == 5'd0) begin
      rs1_data_o = '0;
    end
  end

  // Read port 2: stored value, optional write-through, x0 forced to zero
  always_comb begin
    rs2_data_o = regs[rs2_addr];
`ifdef WB_BYPASS_EN
    if (wb_fire && (wb_addr_i == rs2_addr)) begin
      rs2_data_o = wb_data_i;
    end
`endif
    if (rs2_addr == 5'd0) begin
      rs2_data_o = '0;
    end
  end

  // R-type decode: only the ten base-ISA funct7/funct3 pairs are legal
  always_comb begin
    legal   = 1'b0;
    alu_sel = ALU_ADD;
    if (opcode == OPC_RTYPE) begin
      if (funct7 == F7_BASE) begin
        legal = 1'b1;
        case (funct3)
          3'b000:  alu_sel = ALU_ADD;
          3'b001:  alu_sel = ALU_SLL;
          3'b010:  alu_sel = ALU_SLT;
          3'b011:  alu_sel = ALU_SLTU;
          3'b100:  alu_sel = ALU_XOR;
          3'b101:  alu_sel = ALU_SRL;
          3'b110:  alu_sel = ALU_OR;
          default: alu_sel = ALU_AND;
        endcase
      end else if (funct7 == F7_ALT) begin
        case (funct3)
          3'b000: begin
            legal   = 1'b1;
            alu_sel = ALU_SUB;
          end
          3'b101: begin
            legal   = 1'b1;
            alu_sel = ALU_SRA;
          end
          default: begin
            legal   = 1'b0;
            alu_sel = ALU_ADD;
          end
        endcase
      end
    end
  end

  // An illegal instruction reports ALU select 0 and never writes rd.
  assign rd_addr_o   = rd_addr;
  assign alu_ctrl_o  = legal ? alu_sel : 4'b0000;
  assign illegal_o   = !legal;
  assign reg_write_o = legal && (rd_addr != 5'd0);

  // Sticky illegal flag and retired counter (counter wraps naturally)
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_sticky_o <= 1'b0;
      retired_cnt_o    <= '0;
    end else begin
      if (!legal) begin
        illegal_sticky_o <= 1'b1;
      end
      if (legal) begin
        retired_cnt_o <= retired_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed steps then randomized traffic, all checked
// against a behavioural model (array register file, table-driven decode,
// modulo counter). Counter width is narrowed to 4 so wrap is reachable.
module tb_id_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [31:0]      instr;
  logic             wb_en;
  logic [4:0]       wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [4:0]       rd_addr;
  logic [3:0]       alu_ctrl;
  logic             reg_write;
  logic             illegal;
  logic             illegal_sticky;
  logic [CNT_W-1:0] retired_cnt;

  id_stage #(.XLEN(XLEN), .NREG(32), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .instr_data_i     (instr),
    .wb_en_i          (wb_en),
    .wb_addr_i        (wb_addr),
    .wb_data_i        (wb_data),
    .rs1_data_o       (rs1_data),
    .rs2_data_o       (rs2_data),
    .rd_addr_o        (rd_addr),
    .alu_ctrl_o       (alu_ctrl),
    .reg_write_o      (reg_write),
    .illegal_o        (illegal),
    .illegal_sticky_o (illegal_sticky),
    .retired_cnt_o    (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] code;
  } op_t;

  op_t         ops [10];
  logic [31:0] m_regs [32];
  int          m_cnt;
  logic        m_sticky;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic void model_decode(input logic [31:0] ins, output logic lg,
                                       output logic [3:0] code);
    lg   = 1'b0;
    code = 4'd0;
    if (ins[6:0] == 7'h33) begin
      for (int k = 0; k < 10; k++) begin
        if (ops[k].f7 == ins[31:25] && ops[k].f3 == ins[14:12]) begin
          lg   = 1'b1;
          code = ops[k].code;
        end
      end
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return m_regs[a];
  endfunction

  // Apply inputs, let decode settle, compare every output with the model
  task automatic drive(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic r);
    logic       lg;
    logic [3:0] code;
    instr   = ins;
    wb_en   = we;
    wb_addr = wa;
    wb_data = wd;
    rst     = r;
    #1;
    model_decode(ins, lg, code);
    check("rs1_data",  rs1_data, model_read(ins[19:15]));
    check("rs2_data",  rs2_data, model_read(ins[24:20]));
    check("rd_addr",   32'(rd_addr), 32'(ins[11:7]));
    check("alu_ctrl",  32'(alu_ctrl), 32'(code));
    check("reg_write", 32'(reg_write), 32'(lg && ins[11:7] != 5'd0));
    check("illegal",   32'(illegal), 32'(!lg));
    check("sticky",    32'(illegal_sticky), 32'(m_sticky));
    check("retired",   32'(retired_cnt), 32'(m_cnt));
  endtask

  // Advance one clock edge and move the model forward with the same inputs
  task automatic tick();
    logic       lg;
    logic [3:0] code;
    model_decode(instr, lg, code);
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
      m_cnt    = 0;
      m_sticky = 1'b0;
    end else begin
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      if (lg) m_cnt = (m_cnt + 1) % 16;
      else    m_sticky = 1'b1;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    int          kind;
    int          idx;
    logic [31:0] r;
    kind = int'($urandom_range(0, 9));
    r    = $urandom;
    if (kind <= 5) begin
      idx = int'($urandom_range(0, 9));
      return rtype(ops[idx].f7, r[24:20], r[19:15], ops[idx].f3, r[11:7]);
    end else if (kind <= 7) begin
      return {(r[31] ? 7'h20 : r[31:25]), r[24:7], 7'h33};
    end
    return r;
  endfunction

  initial begin
    logic [31:0] ri;
    logic [31:0] rv;
    logic [4:0]  wa;

    ops[0] = '{7'h00, 3'd0, 4'b0000};
    ops[1] = '{7'h00, 3'd1, 4'b0010};
    ops[2] = '{7'h00, 3'd2, 4'b0011};
    ops[3] = '{7'h00, 3'd3, 4'b0100};
    ops[4] = '{7'h00, 3'd4, 4'b0101};
    ops[5] = '{7'h00, 3'd5, 4'b0110};
    ops[6] = '{7'h00, 3'd6, 4'b1000};
    ops[7] = '{7'h00, 3'd7, 4'b1001};
    ops[8] = '{7'h20, 3'd0, 4'b0001};
    ops[9] = '{7'h20, 3'd5, 4'b0111};
    for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
    m_cnt    = 0;
    m_sticky = 1'b0;

    // Initial reset, outputs not compared before state is defined
    instr = 32'h0000_0033; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; rst = 1'b1;
    tick();

    // Reset clears a written register; a write during reset is dropped
    drive(32'h0000_0033, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    tick();
    drive(rtype(7'h00, 5'd6, 5'd5, 3'd0, 5'd1), 1'b1, 5'd6, 32'h0000_1234, 1'b1);
    check("x5_before_rst", rs1_data, 32'hDEAD_BEEF);
    tick();
    drive(rtype(7'h00, 5'd6, 5'd5, 3'd0, 5'd1), 1'b0, 5'd0, 32'd0, 1'b0);
    check("x5_after_rst", rs1_data, 32'd0);
    check("x6_dropped", rs2_data, 32'd0);
    check("cnt_after_rst", 32'(retired_cnt), 32'd0);
    check("sticky_after_rst", 32'(illegal_sticky), 32'd0);
    tick();

    // Write x3 then ADD x1,x3,x0
    drive(32'h0000_0033, 1'b1, 5'd3, 32'h0000_0011, 1'b0);
    tick();
    drive(32'h0001_80B3, 1'b0, 5'd0, 32'd0, 1'b0);
    check("add_rs1", rs1_data, 32'h11);
    check("add_rs2", rs2_data, 32'h0);
    check("add_ctrl", 32'(alu_ctrl), 32'h0);
    check("add_rd", 32'(rd_addr), 32'd1);
    check("add_we", 32'(reg_write), 32'd1);
    tick();

    // x0 protection and rd=0 instruction
    drive(32'h0000_0033, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    check("rd0_we", 32'(reg_write), 32'd0);
    check("rd0_illegal", 32'(illegal), 32'd0);
    tick();
    drive(rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd2), 1'b0, 5'd0, 32'd0, 1'b0);
    check("x0_read", rs1_data, 32'd0);
    tick();

    // Decode sweep and sticky flag
    drive(32'h4000_0033, 1'b0, 5'd0, 32'd0, 1'b0);
    check("sub_ctrl", 32'(alu_ctrl), 32'b0001);
    tick();
    drive(32'h4000_5033, 1'b0, 5'd0, 32'd0, 1'b0);
    check("sra_ctrl", 32'(alu_ctrl), 32'b0111);
    tick();
    drive(32'h4000_7033, 1'b0, 5'd0, 32'd0, 1'b0);
    check("bad_f3_illegal", 32'(illegal), 32'd1);
    check("bad_f3_ctrl", 32'(alu_ctrl), 32'd0);
    check("sticky_same_cycle", 32'(illegal_sticky), 32'd0);
    tick();
    drive(32'h0000_00B3, 1'b0, 5'd0, 32'd0, 1'b0);
    check("sticky_set", 32'(illegal_sticky), 32'd1);
    tick();
    drive(32'h0000_0013, 1'b0, 5'd0, 32'd0, 1'b0);
    check("opimm_illegal", 32'(illegal), 32'd1);
    check("sticky_holds", 32'(illegal_sticky), 32'd1);
    tick();

    // Same-cycle read/write of x7
    drive(32'h0000_0033, 1'b1, 5'd7, 32'h1, 1'b0);
    tick();
    drive(rtype(7'h00, 5'd0, 5'd7, 3'd0, 5'd1), 1'b1, 5'd7, 32'h2, 1'b0);
`ifdef WB_BYPASS_EN
    check("x7_same_cycle", rs1_data, 32'h2);
`else
    check("x7_same_cycle", rs1_data, 32'h1);
`endif
    tick();
    drive(rtype(7'h00, 5'd0, 5'd7, 3'd0, 5'd1), 1'b0, 5'd0, 32'd0, 1'b0);
    check("x7_next_cycle", rs1_data, 32'h2);
    tick();

    // Counter wrap: 16 legal instructions from reset
    drive(32'h0000_0033, 1'b0, 5'd0, 32'd0, 1'b1);
    tick();
    for (int n = 0; n < 16; n++) begin
      drive(rtype(7'h00, 5'd1, 5'd2, 3'(n % 8), 5'd3), 1'b0, 5'd0, 32'd0, 1'b0);
      tick();
    end
    drive(32'h0000_0013, 1'b0, 5'd0, 32'd0, 1'b0);
    check("cnt_wrapped", 32'(retired_cnt), 32'd0);
    tick();
    drive(32'h0000_0033, 1'b0, 5'd0, 32'd0, 1'b0);
    check("cnt_illegal_no_inc", 32'(retired_cnt), 32'd0);
    tick();
    drive(32'h0000_0033, 1'b0, 5'd0, 32'd0, 1'b0);
    check("cnt_one", 32'(retired_cnt), 32'd1);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      ri = rand_instr();
      rv = $urandom;
      wa = ($urandom_range(0, 2) == 0) ? ri[19:15] : 5'($urandom_range(0, 31));
      drive(ri, ($urandom_range(0, 3) != 0), wa, rv, ($urandom_range(0, 49) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Decode stage for the single-cycle R-type RISC-V core. It sits directly downstream of the fetch stage and consumes its 32-bit instruction word. It holds the 32x32 architectural register file and reads rs1/rs2 combinationally. It decodes R-type opcode/funct3/funct7 into a 4-bit ALU control and a write enable. It accepts the writeback (rd, data, enable) from the execute/writeback path, and keeps a sticky illegal-instruction flag and a retired-instruction counter.

Parameters:
XLEN, 32, datapath and register width
NREG, 32, number of architectural registers (addr width = 5)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
instr_data_i  input  32  instruction word from fetch stage
wb_en_i  input  1  register-file write enable from writeback
wb_addr_i  input  5  writeback destination register
wb_data_i  input  XLEN  writeback data
rs1_data_o  output  XLEN  register-file read of instr[19:15]
rs2_data_o  output  XLEN  register-file read of instr[24:20]
rd_addr_o  output  5  instr[11:7]
alu_ctrl_o  output  4  ALU operation select
reg_write_o  output  1  instruction writes rd (legal R-type, rd != 0)
illegal_o  output  1  current instruction is not a supported R-type
illegal_sticky_o  output  1  set once any illegal instruction is decoded; cleared only by rst
retired_cnt_o  output  CNT_W  count of legal instructions decoded

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (ports clk, rst). rst sampled only at a rising clk edge.
- Reset: all 32 registers <= 0, illegal_sticky_o <= 0, retired_cnt_o <= 0. rst has priority over a same-cycle writeback; the write is dropped.
- Register file reads are combinational, zero latency. Address 0 always reads 0.
- Writes happen at the rising edge when wb_en_i=1 and wb_addr_i != 0. A write to x0 is ignored.
- Without bypass, a same-cycle read of wb_addr_i returns the old value. The new value is visible the next cycle.
- Decode is combinational. Legal requires opcode instr[6:0] == 7'b0110011 with a legal funct7/funct3 pair:
  - funct7 0000000: funct3 000 ADD=0000, 001 SLL=0010, 010 SLT=0011, 011 SLTU=0100, 100 XOR=0101, 101 SRL=0110, 110 OR=1000, 111 AND=1001.
  - funct7 0100000: funct3 000 SUB=0001, 101 SRA=0111.
  - Any other combination is illegal.
- When illegal: illegal_o=1, alu_ctrl_o=0000, reg_write_o=0.
- reg_write_o = legal AND rd != 0.
- illegal_sticky_o: set at the edge after illegal_o=1 is observed (1-cycle latency). Holds until rst.
- retired_cnt_o: increments by 1 at each rising edge where the instruction is legal and rst=0. Wraps modulo 2^CNT_W (all-ones -> 0).
- Simultaneous events: a writeback and a read of a different register are independent. Counter and sticky flag update in the same cycle as any writeback.
- Reset mid-operation: state clears the next edge. Decode outputs keep following instr_data_i.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: a read port whose address equals wb_addr_i while wb_en_i=1 and address != 0 returns wb_data_i in the same cycle (write-through).
- Undefined: read returns the stored (old) value, as above.
- x0 reads return 0 either way.

Test Plan:
- Reset: hold rst 1 cycle after writing x5=0xDEADBEEF -> x5 reads 0, retired_cnt_o=0, illegal_sticky_o=0.
- Write/read: wb x3=0x00000011 then instr ADD x1,x3,x0 (0x000180B3) -> rs1_data_o=0x11, rs2_data_o=0, alu_ctrl_o=0000, rd_addr_o=1, reg_write_o=1.
- x0 protect: wb_en_i=1, wb_addr_i=0, wb_data_i=0xFFFFFFFF -> next-cycle rs1 read of x0 = 0. rd=0 instruction (0x00000033) -> reg_write_o=0, illegal_o=0.
- Decode sweep: SUB 0x40000033 -> 0001. SRA 0x40005033 -> 0111. funct7 0100000 with funct3 111 (0x40007033) -> illegal_o=1, alu_ctrl_o=0, illegal_sticky_o=1 next cycle and stays 1 after legal instructions. Opcode 0x13 -> illegal.
- Same-cycle read/write on x7 (old 0x1, new 0x2): with WB_BYPASS_EN rs1_data_o=0x2 that cycle; without it 0x1 then 0x2 next cycle.
- Counter wrap: CNT_W=4, 16 legal instructions from reset -> retired_cnt_o returns to 0. An illegal instruction does not increment.
